// File: rtl/cdb_arbiter_if.sv
// Producer-side handshake and CDB broadcast bundle shared by the result
// producers (master) and the CDB arbiter (slave).
interface cdb_arbiter_if #(
    parameter int N_SRC  = 3,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
);
    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC-1:0]        src_ready;
    logic [N_SRC*ROB_W-1:0]  src_rob_tag;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic                    newest_data_valid;
    logic [ROB_W-1:0]        newest_data_rob_tag;
    logic [DATA_W-1:0]       newest_data;
    logic [1:0]              grant_src;

    modport master (
        output src_valid, src_rob_tag, src_data,
        input  src_ready, newest_data_valid, newest_data_rob_tag, newest_data, grant_src
    );

    modport slave (
        input  src_valid, src_rob_tag, src_data,
        output src_ready, newest_data_valid, newest_data_rob_tag, newest_data, grant_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per producer, round-robin
// pick of one buffered result per cycle, registered CDB broadcast.
module cdb_arbiter #(
    parameter int N_SRC  = 3,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]  buf_valid;
    logic [ROB_W-1:0]  buf_tag  [N_SRC];
    logic [DATA_W-1:0] buf_data [N_SRC];
    logic [PTR_W-1:0]  ptr;

    logic [N_SRC-1:0]  grant;
    logic [N_SRC-1:0]  ready;
    logic [N_SRC-1:0]  take;
    logic [PTR_W-1:0]  winner;
    logic              found;
    logic [PTR_W-1:0]  idx;
    int                sum;

    logic              bc_valid;
    logic [ROB_W-1:0]  bc_tag;
    logic [DATA_W-1:0] bc_data;
    logic [1:0]        bc_src;

    // Round-robin search starting at the pointer, wrapping modulo N_SRC.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        sum    = 0;
        for (int k = 0; k < N_SRC; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N_SRC) sum = sum - N_SRC;
            idx = PTR_W'(sum);
            if (!found && buf_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

    // A buffer being drained this cycle can accept its next result on the same edge.
    assign ready = {N_SRC{~flush}} & (~buf_valid | grant);
    assign take  = bus.src_valid & ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= '0;
            ptr       <= '0;
            bc_valid  <= 1'b0;
            bc_tag    <= '0;
            bc_data   <= '0;
            bc_src    <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                buf_tag[i]  <= '0;
                buf_data[i] <= '0;
            end
        end else if (flush) begin
            buf_valid <= '0;
            bc_valid  <= 1'b0;
            bc_tag    <= '0;
            bc_data   <= '0;
            bc_src    <= '0;
        end else begin
            if (found) begin
                ptr      <= (winner == PTR_W'(N_SRC - 1)) ? '0 : winner + 1'b1;
                bc_valid <= 1'b1;
                bc_tag   <= buf_tag[winner];
                bc_data  <= buf_data[winner];
                bc_src   <= 2'(winner);
            end else begin
                bc_valid <= 1'b0;
                bc_tag   <= '0;
                bc_data  <= '0;
                bc_src   <= '0;
            end
            // Zero-tag handshakes are consumed without occupying the buffer.
            for (int i = 0; i < N_SRC; i++) begin
                if (take[i] && (bus.src_rob_tag[i*ROB_W +: ROB_W] != '0)) begin
                    buf_valid[i] <= 1'b1;
                    buf_tag[i]   <= bus.src_rob_tag[i*ROB_W +: ROB_W];
                    buf_data[i]  <= bus.src_data[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.src_ready           = ready;
    assign bus.newest_data_valid   = bc_valid;
    assign bus.newest_data_rob_tag = bc_tag;
    assign bus.newest_data         = bc_data;
    assign bus.grant_src           = bc_src;
endmodule
